// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Stream, status and control bundle of the UART receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [DATA_WIDTH-1:0] m_axis_data;
  logic                  m_axis_valid;
  logic                  m_axis_ready;
  logic [ADDR_WIDTH:0]   level;
  logic                  almost_full;
  logic                  overflow;
  logic [7:0]            drop_cnt;
  logic                  clr_overflow;

  // Environment side: UART receiver, host consumer and status reader.
  modport master (
    output s_axis_data, s_axis_valid, m_axis_ready, clr_overflow,
    input  s_axis_ready, m_axis_data, m_axis_valid, level, almost_full,
           overflow, drop_cnt
  );

  // FIFO side.
  modport slave (
    input  s_axis_data, s_axis_valid, m_axis_ready, clr_overflow,
    output s_axis_ready, m_axis_data, m_axis_valid, level, almost_full,
           overflow, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Show-ahead circular byte FIFO behind a UART receiver, with level,
//            almost-full and sticky overrun tracking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_fifo_if.slave bus
);

  localparam int                  c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_PTR_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] c_AFULL   = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [0:c_DEPTH-1];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_q,  level_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign w_pop  = !w_empty && bus.m_axis_ready;
  assign w_push = bus.s_axis_valid && (!w_full || w_pop);
  assign w_drop = bus.s_axis_valid && w_full && !w_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_PTR_ONE;
      2'b01:   level_d = level_q - c_PTR_ONE;
      default: level_d = level_q;
    endcase

    // A drop coinciding with a clear restarts the count at one.
    if (w_drop) begin
      overflow_d = 1'b1;
      if (bus.clr_overflow) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.s_axis_data;
    end
  end

  assign bus.m_axis_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign bus.m_axis_valid = !w_empty;
  assign bus.s_axis_ready = !w_full;
  assign bus.level        = level_q;
  assign bus.almost_full  = (level_q >= c_AFULL);
  assign bus.overflow     = overflow_q;
  assign bus.drop_cnt     = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed vector table plus hand sequences for uart_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AFULL_LEVEL(12)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] el;
    logic       esr;
    logic       eaf;
    logic       eov;
    logic [7:0] edc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add_vec(input logic sv, input logic [7:0] sd,
                                  input logic mr, input logic clr,
                                  input logic ev, input logic [7:0] ed,
                                  input logic [4:0] el, input logic esr,
                                  input logic eaf, input logic eov,
                                  input logic [7:0] edc);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.esr = esr;
    v.eaf = eaf; v.eov = eov; v.edc = edc;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic sv, input logic [7:0] sd, input logic mr,
                       input logic clr);
    bus.s_axis_valid = sv;
    bus.s_axis_data  = sd;
    bus.m_axis_ready = mr;
    bus.clr_overflow = clr;
  endtask

  // One cycle of stimulus; returns #1 after the edge with inputs idle.
  task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr,
                       input logic clr);
    drive(sv, sd, mr, clr);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string name, input int idx, input logic ev,
                           input logic [7:0] ed, input logic [4:0] el,
                           input logic esr, input logic eaf, input logic eov,
                           input logic [7:0] edc);
    chk({name, "_valid"}, idx, 32'(bus.m_axis_valid), 32'(ev));
    if (ev) chk({name, "_data"}, idx, 32'(bus.m_axis_data), 32'(ed));
    chk({name, "_level"}, idx, 32'(bus.level), 32'(el));
    chk({name, "_sready"}, idx, 32'(bus.s_axis_ready), 32'(esr));
    chk({name, "_afull"}, idx, 32'(bus.almost_full), 32'(eaf));
    chk({name, "_ovf"}, idx, 32'(bus.overflow), 32'(eov));
    chk({name, "_dcnt"}, idx, 32'(bus.drop_cnt), 32'(edc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         lvl;
    int         sent;
    int         got;
    int         cnt;
    int         cyc;
    logic       sv;
    logic       mr;
    logic       pop;
    logic [7:0] sd;

    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte in and out.
    add_vec(1, 8'hA5, 0, 0, 1, 8'hA5, 5'd1, 1, 0, 0, 8'd0);
    add_vec(0, 8'h00, 1, 0, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);
    // Fill 0x00..0x12 without reading: last three bytes are dropped.
    for (int i = 0; i < 19; i++) begin
      lvl = (i < 16) ? i + 1 : 16;
      add_vec(1, 8'(i), 0, 0, 1, 8'h00, 5'(lvl), lvl != 16, lvl >= 12,
              i >= 16, 8'((i >= 16) ? i - 15 : 0));
    end
    // Drain: head after each pop is the next byte in order.
    for (int k = 0; k < 16; k++) begin
      lvl = 15 - k;
      add_vec(0, 8'h00, 1, 0, k < 15, 8'(k + 1), 5'(lvl), 1, lvl >= 12, 1, 8'd3);
    end
    add_vec(0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);
    // Refill, then push into full FIFO while popping.
    for (int i = 0; i < 16; i++) begin
      add_vec(1, 8'(i), 0, 0, 1, 8'h00, 5'(i + 1), (i + 1) != 16, (i + 1) >= 12,
              0, 8'd0);
    end
    add_vec(1, 8'h55, 1, 0, 1, 8'h01, 5'd16, 0, 1, 0, 8'd0);
    for (int k = 0; k < 16; k++) begin
      lvl = 15 - k;
      add_vec(0, 8'h00, 1, 0, k < 15, (k + 1 < 15) ? 8'(k + 2) : 8'h55,
              5'(lvl), 1, lvl >= 12, 0, 8'd0);
    end

    // Reset held for three cycles, then idle check.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_state("reset", 0, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);
    cycle(0, 8'h00, 1, 0);
    chk_state("idle", 0, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].clr);
      chk_state("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].esr,
                vecs[i].eaf, vecs[i].eov, vecs[i].edc);
    end

    // Streaming across several wraps with random gaps and backpressure.
    sent = 0; got = 0; cnt = 0; cyc = 0;
    while ((sent < 40 || got < 40) && cyc < 3000) begin
      sv = (sent < 40) && bus.s_axis_ready && ($urandom_range(0, 2) != 0);
      sd = 8'($urandom_range(0, 255));
      mr = 1'($urandom_range(0, 1));
      pop = bus.m_axis_valid && mr;
      if (sv) begin
        exp_q.push_back(sd);
        sent++;
      end
      if (pop) begin
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        chk("stream_data", got, 32'(bus.m_axis_data), 32'(exp_b));
        got++;
      end
      cnt = cnt + (sv ? 1 : 0) - (pop ? 1 : 0);
      cycle(sv, sd, mr, 0);
      chk("stream_level", cyc, 32'(bus.level), 32'(cnt));
      cyc++;
    end
    chk("stream_done", 0, 32'(got), 32'd40);
    chk("stream_ovf", 0, 32'(bus.overflow), 32'd0);
    chk("stream_empty", 0, 32'(bus.m_axis_valid), 32'd0);

    // Overrun, then clear coinciding with another drop.
    for (int i = 0; i < 18; i++) cycle(1, 8'(8'h80 + i), 0, 0);
    chk_state("ovr", 0, 1, 8'h80, 5'd16, 0, 1, 1, 8'd2);
    cycle(1, 8'hEE, 0, 1);
    chk_state("clr_drop", 0, 1, 8'h80, 5'd16, 0, 1, 1, 8'd1);
    repeat (9) cycle(0, 8'h00, 1, 0);
    chk_state("part", 0, 1, 8'h89, 5'd7, 1, 0, 1, 8'd1);

    // Asynchronous reset mid-cycle with seven bytes held.
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("areset", 0, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 8'h00, 1, 0);
    chk_state("post_rst", 0, 0, 8'h00, 5'd0, 1, 0, 0, 8'd0);
    cycle(1, 8'h3C, 0, 0);
    chk_state("post_push", 0, 1, 8'h3C, 5'd1, 1, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
